// File: rtl/sram_stream_reader.sv
// rtl/sram_stream_reader.sv - burst reader from an 8K x 32b SRAM read port onto a valid/ready stream
module sram_stream_reader #(
    parameter int AW = 13,
    parameter int DW = 32,
    parameter int LW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          csbn,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state;
    logic [AW-1:0] base;
    logic [LW-1:0] blen;
    logic [LW-1:0] issued;
    logic [LW-1:0] accepted;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    count;
    logic [DW-1:0] slot1_data;
    logic          slot1_last;

    logic          pop;
    logic [2:0]    occupancy;
    logic          issue_last;

    // Occupancy counts buffered words plus the read in flight, minus the word leaving now.
    assign pop        = m_valid & m_ready;
    assign occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign csbn       = (state == RUN) && (issued < blen) && (occupancy < 3'd2);
    assign raddr      = base + issued[AW-1:0];
    assign issue_last = (issued == blen - 1'b1);
    assign busy       = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            base          <= '0;
            blen          <= '0;
            issued        <= '0;
            accepted      <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            count         <= 2'd0;
            slot1_data    <= '0;
            slot1_last    <= 1'b0;
            m_valid       <= 1'b0;
            m_data        <= '0;
            m_last        <= 1'b0;
            done          <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= csbn;
            inflight_last <= csbn & issue_last;
            if (csbn) begin
                issued <= issued + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            base     <= base_addr;
                            blen     <= len;
                            issued   <= '0;
                            accepted <= '0;
                            state    <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        accepted <= accepted + 1'b1;
                        if (accepted + 1'b1 == blen) begin
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end
                    // m_* registers are the buffer head; slot1 is the second entry.
                    case ({pop, inflight})
                        2'b01: begin
                            if (count == 2'd0) begin
                                m_valid <= 1'b1;
                                m_data  <= rdata;
                                m_last  <= inflight_last;
                                count   <= 2'd1;
                            end else begin
                                slot1_data <= rdata;
                                slot1_last <= inflight_last;
                                count      <= 2'd2;
                            end
                        end
                        2'b10: begin
                            if (count == 2'd2) begin
                                m_data <= slot1_data;
                                m_last <= slot1_last;
                                count  <= 2'd1;
                            end else begin
                                m_valid <= 1'b0;
                                m_last  <= 1'b0;
                                count   <= 2'd0;
                            end
                        end
                        2'b11: begin
                            if (count == 2'd2) begin
                                m_data     <= slot1_data;
                                m_last     <= slot1_last;
                                slot1_data <= rdata;
                                slot1_last <= inflight_last;
                            end else begin
                                m_data <= rdata;
                                m_last <= inflight_last;
                            end
                        end
                        default: ;
                    endcase
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_stream_reader.sv
// tb/tb_sram_stream_reader.sv - randomized scoreboard bench for sram_stream_reader
module tb_sram_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [12:0] base_addr = '0;
    logic [13:0] len = '0;
    logic        busy, done, csbn;
    logic [12:0] raddr;
    logic [31:0] rdata = '0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic        m_last;

    sram_stream_reader dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .csbn(csbn), .raddr(raddr), .rdata(rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];
    always @(posedge clk) if (csbn) rdata <= mem[raddr];

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q [$];
    int          exp_addr [$];
    int          hs_count = 0;
    int          ready_mode = 0;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    initial begin
        int rcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            rcnt++;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // Monitor: issue order, read credit, stall stability and data ordering.
    initial begin
        int          pend = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_data = '0;
        logic        prev_last = 0;
        logic [32:0] e;
        int          a;
        int          pop;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 0;
                prev_stall = 0;
            end else begin
                pop = (m_valid && m_ready) ? 1 : 0;
                if (csbn) begin
                    if (exp_addr.size() == 0) begin
                        chk("csbn_unexpected", 1, 0);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("raddr", raddr, a);
                    end
                    chk("read_credit", (pend - pop) < 2, 1);
                end
                if (prev_stall) begin
                    chk("stall_valid", m_valid, 1);
                    chk("stall_data", m_data, prev_data);
                    chk("stall_last", m_last, prev_last);
                end
                if (pop) begin
                    hs_count++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_data", m_data, e[31:0]);
                        chk("m_last", m_last, e[32]);
                    end
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                pend       = pend + (csbn ? 1 : 0) - pop;
            end
        end
    end

    task automatic run_burst(input int b, input int l, input int exp_lat, input bit poke);
        int cyc;
        int limit;
        for (int i = 0; i < l; i++) begin
            exp_addr.push_back((b + i) % 8192);
            exp_q.push_back({(i == l - 1), mem[(b + i) % 8192]});
        end
        limit = 4 * l + 100;
        base_addr = b[12:0];
        len = l[13:0];
        start = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (l == 0) chk("busy_len0", busy, 0);
            if (cyc == 1 && l > 0) chk("busy_run", busy, 1);
            if (cyc > limit) begin
                chk("done_timeout", cyc, limit);
                break;
            end
            if (poke && cyc == 5) begin
                base_addr = 13'($urandom);
                len = 14'd3;
                start = 1'b1;
            end
            @(posedge clk);
            cyc++;
            #1 start = 1'b0;
        end
        if (exp_lat > 0) chk("done_latency", cyc, exp_lat);
        chk("busy_at_done", busy, 0);
        chk("words_left", exp_q.size(), 0);
        chk("reads_left", exp_addr.size(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_after", busy, 0);
    endtask

    initial begin
        int hs0;
        int cyc;
        for (int i = 0; i < 8192; i++) mem[i] = i + 32'h100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_outputs", {busy, done, csbn, raddr, m_valid, m_data, m_last}, 0);
        end

        ready_mode = 0;
        run_burst(10, 4, 0, 0);
        run_burst(20, 1, 4, 0);
        ready_mode = 1;
        run_burst(10, 4, 0, 0);
        run_burst(100, 8, 0, 1);
        ready_mode = 0;
        run_burst(8190, 4, 0, 0);
        run_burst(5, 0, 1, 0);

        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        for (int k = 0; k < 24; k++) begin
            ready_mode = $urandom_range(0, 2);
            run_burst($urandom_range(0, 8191), $urandom_range(1, 40), 0, 0);
        end
        ready_mode = 0;
        run_burst($urandom_range(0, 8191), 8192, 0, 0);

        // Abort an 8-word burst after two words.
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(50 + i);
            exp_q.push_back({(i == 7), mem[50 + i]});
        end
        hs0 = hs_count;
        base_addr = 13'd50;
        len = 14'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (hs_count - hs0 < 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached", hs_count - hs0 >= 2, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        exp_q.delete();
        exp_addr.delete();
        @(negedge clk);
        chk("reset_outputs", {busy, done, csbn, raddr, m_valid, m_data, m_last}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_done_after_reset", done, 0);
        end
        run_burst(0, 2, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
